// File: rtl/spi_cmd_handler.sv
// Command dispatcher behind the SPI slave: decodes 32-bit frames, updates the data and LED
// registers, and queues 24-bit responses for read opcodes.
module spi_cmd_handler #(
  parameter int unsigned LED_W     = 16,
  parameter logic [15:0] INIT_LEDS = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      rd_data,
  input  logic             rd_data_available,
  output logic             rd_ack,
  input  logic             wr_buffer_free,
  output logic             wr_en,
  output logic [23:0]      wr_data,
  output logic [LED_W-1:0] leds,
  output logic [15:0]      cmd_count,
  output logic [7:0]       err_count,
  output logic             busy
);

  typedef enum logic [2:0] {StIdle, StExec, StWaitWr, StAck, StWaitClr} state_e;

  state_e      state_q;
  logic [7:0]  opcode_q;
  logic [15:0] payload_q;
  logic [15:0] data_reg_q;
  logic [15:0] leds_ext;
  logic        is_read;
  logic        unused_hi;

  // The top byte of each frame carries nothing for this block.
  assign unused_hi = ^rd_data[31:24];
  assign is_read   = (opcode_q == 8'h03) || (opcode_q == 8'h05);

  always_comb begin
    leds_ext = '0;
    leds_ext[LED_W-1:0] = leds;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      opcode_q   <= '0;
      payload_q  <= '0;
      data_reg_q <= '0;
      leds       <= INIT_LEDS[LED_W-1:0];
      cmd_count  <= '0;
      err_count  <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      rd_ack     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      rd_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rd_data_available) begin
            opcode_q  <= rd_data[7:0];
            payload_q <= rd_data[23:8];
            state_q   <= StExec;
            busy      <= 1'b1;
          end
        end
        StExec: begin
          if (opcode_q <= 8'h05) begin
            cmd_count <= cmd_count + 16'd1;
          end else if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
          case (opcode_q)
            8'h01: begin
              data_reg_q <= '0;
              leds       <= INIT_LEDS[LED_W-1:0];
            end
            8'h02:   data_reg_q <= ~payload_q;
            8'h03:   wr_data    <= {8'h00, ~data_reg_q};
            8'h04:   leds       <= payload_q[LED_W-1:0];
            8'h05:   wr_data    <= {8'h00, leds_ext};
            default: ;
          endcase
          if (is_read) begin
            // Launch the write pulse straight away if the slave already has room.
            wr_en   <= wr_buffer_free;
            state_q <= StWaitWr;
          end else begin
            rd_ack  <= 1'b1;
            state_q <= StAck;
          end
        end
        StWaitWr: begin
          // Skip the cycle after a pulse so wr_buffer_free has time to update.
          if (wr_en) begin
            rd_ack  <= 1'b1;
            state_q <= StAck;
          end else if (wr_buffer_free) begin
            wr_en <= 1'b1;
          end
        end
        StAck: state_q <= StWaitClr;
        StWaitClr: begin
          if (!rd_data_available) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_handler.md
# spi_cmd_handler

Command dispatcher that sits directly downstream of the SPI slave. It consumes each 32-bit frame the slave presents on its read-side handshake and decodes the opcode. It executes the command against a local 16-bit data register and an LED register, and queues a 24-bit response into the slave's write side, which the host reads on its next frame.

## Interface
- `LED_W`, 16: LED register width, 1..16.
- `INIT_LEDS`, 0: LED register value after reset and after opcode 0x01.

- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `rd_data` in 32: frame from the SPI slave; [7:0] opcode, [23:8] payload, [31:24] ignored.
- `rd_data_available` in 1: frame valid; held until acknowledged and cleared by the slave.
- `rd_ack` out 1: one-cycle pulse acknowledging the current frame.
- `wr_buffer_free` in 1: slave can accept a response word.
- `wr_en` out 1: one-cycle pulse queuing `wr_data`.
- `wr_data` out 24: response word; [15:0] value, [23:16] always 0.
- `leds` out LED_W: LED register.
- `cmd_count` out 16: valid opcodes executed; wraps at 0xFFFF→0.
- `err_count` out 8: unknown opcodes; saturates at 0xFF.
- `busy` out 1: high in every state except IDLE.

## Operation
- State machine:
  - IDLE: if `rd_data_available`=1, latch opcode and payload, go to EXEC.
  - EXEC: execute the latched command (see the opcode list below). Read opcodes go to WAIT_WR; all others go to ACK.
  - WAIT_WR: hold `wr_data` stable. When `wr_buffer_free`=1, pulse `wr_en` for one cycle and go to ACK. There is no timeout.
  - ACK: pulse `rd_ack` for one cycle, go to WAIT_CLR.
  - WAIT_CLR: wait until `rd_data_available`=0, then go to IDLE. This prevents re-executing the same frame, because the slave drops `rd_data_available` only at a frame boundary.
- Opcodes (latched byte):
  - 0x00 nop: no register change. Increments `cmd_count`.
  - 0x01 init: `data_reg`←0, `leds`←INIT_LEDS. Increments `cmd_count`. Counters are not cleared.
  - 0x02 write inverted: `data_reg`←~payload.
  - 0x03 read inverted: `wr_data`←{8'h00, ~`data_reg`}, so the host reads back the value it last wrote with 0x02.
  - 0x04 write leds: `leds`←payload[LED_W-1:0].
  - 0x05 read leds: `wr_data`←{8'h00, zero-extended `leds`}.
  - Any other value: no register change. Increments `err_count`, saturating. Acknowledged, no response queued.
- `cmd_count` increments in EXEC for 0x00–0x05.
- `wr_data` holds its last value outside WAIT_WR. It is 0 after reset.
- Only one response is queued per command. `wr_en` is never asserted on two consecutive cycles, because the slave's `wr_buffer_free` lags by one cycle.

## Timing
- Reset values:
  - `rd_ack`=0, `wr_en`=0, `wr_data`=0, `busy`=0.
  - `leds`=INIT_LEDS, `data_reg`=0, `cmd_count`=0, `err_count`=0.
  - State returns to IDLE.
- Reset mid-operation: takes effect on the next edge from any state. Any pending `wr_en` or `rd_ack` pulse is dropped, and the frame is not acknowledged. If `rd_data_available` is still high after reset, the frame is re-executed.
- Write and non-read commands: `rd_data_available` sampled high in cycle N; register updated at the end of N+1; `rd_ack` high in N+2; then WAIT_CLR.
- Read commands with `wr_buffer_free`=1: `wr_en` high in N+2; `rd_ack` high in N+3.
- If `wr_buffer_free`=0, WAIT_WR stalls and `rd_ack` is withheld. The slave does not overwrite `rd_data` while it is unacknowledged.
- If `rd_data_available` drops in WAIT_CLR on the same cycle it is entered, return to IDLE on the next cycle.

## Test plan
- Reset → `leds`=INIT_LEDS, `wr_data`=0, counters 0, `busy`=0. Then frame 0x0000_1234_02 → after ack, frame 0x03 → `wr_en` once with `wr_data`=0x001234; `cmd_count`=2.
- Frame opcode 0x04, payload 0xA5C3 → `leds`=0xA5C3 two cycles after `rd_data_available`; single `rd_ack`; no `wr_en`. Then 0x05 → `wr_data`=0x00A5C3.
- Hold `wr_buffer_free`=0 for 20 cycles during a 0x03 → `busy` high, no `wr_en`/`rd_ack`. Release → `wr_en` next cycle, `rd_ack` the cycle after.
- Keep `rd_data_available` high 10 cycles after `rd_ack` → exactly one execution. `cmd_count` +1, state stays WAIT_CLR.
- Send 300 frames with opcode 0x7F → `err_count`=0xFF, `cmd_count` unchanged, 300 acks, no `wr_en`.
- Assert `reset` in WAIT_WR → next cycle state IDLE, `wr_en`=0. With `rd_data_available` still high, the command re-executes once.
